// File: rtl/rx_depacketizer.sv
// rx_depacketizer: hunts the frame sync word in a hard-decided serial bit
// stream, parses the 24-bit header (length + check) and emits the payload as
// an AXI-Stream-style byte stream with first/last markers.
module rx_depacketizer #(
    parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
    parameter int unsigned SYNC_TOL  = 0,
    parameter int unsigned MAX_LEN   = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_2M,
    input  logic        I,
    input  logic        I_vld,
    output logic [7:0]  O_tdata,
    output logic        O_tvalid,
    input  logic        O_tready,
    output logic        O_tlast,
    output logic        O_tuser,
    output logic [15:0] payload_length,
    output logic        hdr_vld,
    output logic        hdr_err,
    output logic        ovf,
    output logic        pkt_done
);

    typedef enum logic [1:0] {S_SEARCH, S_HEADER, S_PAYLOAD} state_t;

    state_t      r_state, w_state_nxt;
    logic        w_bit_en;
    logic [31:0] r_sr, w_sr_nxt;
    logic [5:0]  w_pop;
    logic        w_sync;
    logic [4:0]  r_bit_cnt;
    logic [23:0] r_hdr, w_hdr_nxt;
    logic [15:0] w_len;
    logic [7:0]  w_chk;
    logic        w_hdr_ok;
    logic [7:0]  r_byte, w_byte_nxt;
    logic [15:0] r_byte_cnt;
    logic        w_hdr_done, w_byte_done, w_first, w_last;
    logic        w_hs, w_ovf, w_load;

    assign w_bit_en   = ce_2M & I_vld;
    assign w_sr_nxt   = {r_sr[30:0], I};
    assign w_hdr_nxt  = {r_hdr[22:0], I};
    assign w_byte_nxt = {r_byte[6:0], I};
    assign w_len      = w_hdr_nxt[23:8];
    assign w_chk      = w_hdr_nxt[7:0];

    // Hamming distance between the window (including this bit) and the sync word
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < 32; k++) begin
            w_pop = w_pop + {5'd0, w_sr_nxt[k] ^ SYNC_WORD[k]};
        end
    end

    assign w_sync   = ({26'd0, w_pop} <= SYNC_TOL);
    assign w_hdr_ok = (w_chk == (w_len[15:8] ^ w_len[7:0])) &&
                      (w_len != 16'd0) && ({16'd0, w_len} <= MAX_LEN);

    assign w_hdr_done  = w_bit_en && (r_state == S_HEADER)  && (r_bit_cnt == 5'd23);
    assign w_byte_done = w_bit_en && (r_state == S_PAYLOAD) && (r_bit_cnt == 5'd7);
    assign w_first     = (r_byte_cnt == 16'd0);
    assign w_last      = (r_byte_cnt == payload_length - 16'd1);
    assign w_hs        = O_tvalid && O_tready;
    // a byte finishing while the single output slot is still occupied is lost
    assign w_ovf       = w_byte_done && O_tvalid && !O_tready;
    assign w_load      = w_byte_done && !w_ovf;

    // next-state logic; returning to SEARCH makes the next bit a search bit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SEARCH:  if (w_bit_en && w_sync) w_state_nxt = S_HEADER;
            S_HEADER:  if (w_hdr_done) w_state_nxt = w_hdr_ok ? S_PAYLOAD : S_SEARCH;
            S_PAYLOAD: if (w_byte_done && (w_ovf || w_last)) w_state_nxt = S_SEARCH;
            default:   w_state_nxt = S_SEARCH;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_SEARCH;
        else        r_state <= w_state_nxt;
    end

    // sync window and bit counter (header bit index / bit-in-byte index)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_bit_en) begin
            r_sr <= w_sr_nxt;
            case (r_state)
                S_HEADER:  r_bit_cnt <= w_hdr_done  ? 5'd0 : r_bit_cnt + 5'd1;
                S_PAYLOAD: r_bit_cnt <= w_byte_done ? 5'd0 : r_bit_cnt + 5'd1;
                default:   r_bit_cnt <= 5'd0;
            endcase
        end
    end

    // header and payload bit packing, MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr  <= '0;
            r_byte <= '0;
        end else if (w_bit_en) begin
            if (r_state == S_HEADER)  r_hdr  <= w_hdr_nxt;
            if (r_state == S_PAYLOAD) r_byte <= w_byte_nxt;
        end
    end

    // header verdict pulses, latched length and payload byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_vld        <= 1'b0;
            hdr_err        <= 1'b0;
            payload_length <= '0;
            r_byte_cnt     <= '0;
        end else begin
            hdr_vld <= w_hdr_done && w_hdr_ok;
            hdr_err <= w_hdr_done && !w_hdr_ok;
            if (w_hdr_done && w_hdr_ok) payload_length <= w_len;
            if (w_hdr_done)  r_byte_cnt <= 16'd0;
            else if (w_load) r_byte_cnt <= r_byte_cnt + 16'd1;
        end
    end

    // one-entry output register; a new load wins over a same-cycle handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_tdata  <= '0;
            O_tvalid <= 1'b0;
            O_tuser  <= 1'b0;
            O_tlast  <= 1'b0;
            ovf      <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            if (w_load) begin
                O_tdata  <= w_byte_nxt;
                O_tuser  <= w_first;
                O_tlast  <= w_last;
                O_tvalid <= 1'b1;
            end else if (w_hs) begin
                O_tvalid <= 1'b0;
            end
            ovf      <= w_ovf;
            pkt_done <= w_hs && O_tlast;
        end
    end

endmodule
